// File: rtl/layer_tile_scheduler.sv
// layer_tile_scheduler
// Sequences one convolution layer on the systolic core as a loop of output
// tiles: filter group (outer), output row tile, output column tile (inner).
// One weight-load handshake is issued per filter group and one compute
// handshake per tile; a single done pulse marks the end of the layer.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             1-cycle pulse, begin layer (only honoured in idle)
//   ifm_size          square fmap edge (OFM edge is the same)
//   num_filter        filters in the layer
//   busy              high in every state except idle
//   done              1-cycle pulse, layer complete
//   wgt_load_start    1-cycle pulse, load weights for fgroup_idx
//   wgt_load_done     weight FIFO filled (only honoured while waiting for it)
//   tile_start        1-cycle pulse, compute the current tile
//   tile_done         tile written back (only honoured while waiting for it)
//   fgroup_idx        current filter group
//   row_idx, col_idx  current tile coordinates
//   filters_valid     filters used in the current group (1..S)
//   rows_valid        OFM rows in the current tile (1..S)
//   cols_valid        OFM cols in the current tile (1..S)
module layer_tile_scheduler #(
    parameter int unsigned SYSTOLIC_SIZE = 16,
    parameter int unsigned IFM_SIZE_W    = 9,
    parameter int unsigned NUM_FILTER_W  = 11,
    localparam int unsigned LOG2S = $clog2(SYSTOLIC_SIZE),
    localparam int unsigned FG_W  = NUM_FILTER_W - LOG2S,
    localparam int unsigned IDX_W = IFM_SIZE_W - LOG2S + 1,
    localparam int unsigned VAL_W = LOG2S + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [IFM_SIZE_W-1:0]   ifm_size,
    input  logic [NUM_FILTER_W-1:0] num_filter,
    output logic                    busy,
    output logic                    done,
    output logic                    wgt_load_start,
    input  logic                    wgt_load_done,
    output logic                    tile_start,
    input  logic                    tile_done,
    output logic [FG_W-1:0]         fgroup_idx,
    output logic [IDX_W-1:0]        row_idx,
    output logic [IDX_W-1:0]        col_idx,
    output logic [VAL_W-1:0]        filters_valid,
    output logic [VAL_W-1:0]        rows_valid,
    output logic [VAL_W-1:0]        cols_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StLoadWgt,
        StWaitWgt,
        StIssue,
        StWaitTile,
        StAdvance,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [IFM_SIZE_W-1:0]   ifm_q, ifm_d;
    logic [NUM_FILTER_W-1:0] nf_q, nf_d;
    logic [IDX_W-1:0]        nt_q, nt_d;
    logic [FG_W:0]           ng_q, ng_d;
    logic [FG_W-1:0]         fg_q, fg_d;
    logic [IDX_W-1:0]        row_q, row_d;
    logic [IDX_W-1:0]        col_q, col_d;
    logic [VAL_W-1:0]        fv_q, fv_d;
    logic [VAL_W-1:0]        rv_q, rv_d;
    logic [VAL_W-1:0]        cv_q, cv_d;

    // min(S, total - base) in 32 bits so the largest configs cannot wrap.
    function automatic logic [VAL_W-1:0] clip_valid(input logic [31:0] total,
                                                    input logic [31:0] base);
        logic [31:0] rem;
        rem = total - base;
        if (rem >= SYSTOLIC_SIZE) begin
            return VAL_W'(SYSTOLIC_SIZE);
        end
        return VAL_W'(rem);
    endfunction

    always_comb begin
        state_d = state_q;
        ifm_d   = ifm_q;
        nf_d    = nf_q;
        nt_d    = nt_q;
        ng_d    = ng_q;
        fg_d    = fg_q;
        row_d   = row_q;
        col_d   = col_q;
        fv_d    = fv_q;
        rv_d    = rv_q;
        cv_d    = cv_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ifm_d   = ifm_size;
                    nf_d    = num_filter;
                    state_d = StPrep;
                end
            end
            StPrep: begin
                nt_d  = IDX_W'((32'(ifm_q) + SYSTOLIC_SIZE - 1) >> LOG2S);
                ng_d  = (FG_W + 1)'((32'(nf_q) + SYSTOLIC_SIZE - 1) >> LOG2S);
                fg_d  = '0;
                row_d = '0;
                col_d = '0;
                fv_d  = clip_valid(32'(nf_q), 32'd0);
                rv_d  = clip_valid(32'(ifm_q), 32'd0);
                cv_d  = clip_valid(32'(ifm_q), 32'd0);
                if (ifm_q == '0 || nf_q == '0) begin
                    state_d = StDone;
                end else begin
                    state_d = StLoadWgt;
                end
            end
            StLoadWgt: state_d = StWaitWgt;
            StWaitWgt: begin
                if (wgt_load_done) begin
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWaitTile;
            StWaitTile: begin
                if (tile_done) begin
                    state_d = StAdvance;
                end
            end
            StAdvance: begin
                if (col_q != nt_q - IDX_W'(1)) begin
                    col_d   = col_q + IDX_W'(1);
                    state_d = StIssue;
                end else if (row_q != nt_q - IDX_W'(1)) begin
                    col_d   = '0;
                    row_d   = row_q + IDX_W'(1);
                    state_d = StIssue;
                end else if ({1'b0, fg_q} != ng_q - (FG_W + 1)'(1)) begin
                    col_d   = '0;
                    row_d   = '0;
                    fg_d    = fg_q + FG_W'(1);
                    state_d = StLoadWgt;
                end else begin
                    // Last tile: indices stay on it until the next layer's prep.
                    state_d = StDone;
                end
                fv_d = clip_valid(32'(nf_q), 32'(fg_d) << LOG2S);
                rv_d = clip_valid(32'(ifm_q), 32'(row_d) << LOG2S);
                cv_d = clip_valid(32'(ifm_q), 32'(col_d) << LOG2S);
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ifm_q   <= '0;
            nf_q    <= '0;
            nt_q    <= '0;
            ng_q    <= '0;
            fg_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            fv_q    <= '0;
            rv_q    <= '0;
            cv_q    <= '0;
        end else begin
            state_q <= state_d;
            ifm_q   <= ifm_d;
            nf_q    <= nf_d;
            nt_q    <= nt_d;
            ng_q    <= ng_d;
            fg_q    <= fg_d;
            row_q   <= row_d;
            col_q   <= col_d;
            fv_q    <= fv_d;
            rv_q    <= rv_d;
            cv_q    <= cv_d;
        end
    end

    // Strobes are pure decodes of the state register.
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign wgt_load_start = (state_q == StLoadWgt);
    assign tile_start     = (state_q == StIssue);
    assign fgroup_idx     = fg_q;
    assign row_idx        = row_q;
    assign col_idx        = col_q;
    assign filters_valid  = fv_q;
    assign rows_valid     = rv_q;
    assign cols_valid     = cv_q;

endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Self-checking bench for layer_tile_scheduler. The expected layer is an
// ordered list of events (weight load, tile, done) built with plain loops; a
// randomized handshake responder replays it and checks strobe timing.
module tb_layer_tile_scheduler;

    localparam int S    = 16;
    localparam int IW   = 9;
    localparam int NW   = 11;
    localparam int FGW  = NW - 4;
    localparam int IDXW = IW - 4 + 1;
    localparam int VW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [IW-1:0]   ifm_size = '0;
    logic [NW-1:0]   num_filter = '0;
    logic            busy, done, wgt_load_start, tile_start;
    logic            wgt_load_done = 1'b0;
    logic            tile_done = 1'b0;
    logic [FGW-1:0]  fgroup_idx;
    logic [IDXW-1:0] row_idx, col_idx;
    logic [VW-1:0]   filters_valid, rows_valid, cols_valid;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int kind;  // 0 weight load, 1 tile, 2 done
        int g, r, c, fv, rv, cv;
    } evt_t;

    evt_t exp_q[$];

    layer_tile_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .ifm_size       (ifm_size),
        .num_filter     (num_filter),
        .busy           (busy),
        .done           (done),
        .wgt_load_start (wgt_load_start),
        .wgt_load_done  (wgt_load_done),
        .tile_start     (tile_start),
        .tile_done      (tile_done),
        .fgroup_idx     (fgroup_idx),
        .row_idx        (row_idx),
        .col_idx        (col_idx),
        .filters_valid  (filters_valid),
        .rows_valid     (rows_valid),
        .cols_valid     (cols_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int vmin(input int total, input int base);
        int rem;
        rem = total - base;
        return (rem > S) ? S : rem;
    endfunction

    task automatic build_model(input int ifm, input int nf);
        int nt, ng;
        evt_t e;
        exp_q.delete();
        nt = (ifm + S - 1) / S;
        ng = (nf + S - 1) / S;
        if (ifm == 0 || nf == 0) ng = 0;
        for (int g = 0; g < ng; g++) begin
            e = '{0, g, 0, 0, vmin(nf, g * S), vmin(ifm, 0), vmin(ifm, 0)};
            exp_q.push_back(e);
            for (int r = 0; r < nt; r++) begin
                for (int c = 0; c < nt; c++) begin
                    e = '{1, g, r, c, vmin(nf, g * S), vmin(ifm, r * S), vmin(ifm, c * S)};
                    exp_q.push_back(e);
                end
            end
        end
        e = '{2, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(e);
    endtask

    task automatic chk_fields(input string tag, input evt_t e);
        chk({tag, "_fgroup"}, 32'(fgroup_idx), e.g);
        chk({tag, "_row"}, 32'(row_idx), e.r);
        chk({tag, "_col"}, 32'(col_idx), e.c);
        chk({tag, "_filters_valid"}, 32'(filters_valid), e.fv);
        chk({tag, "_rows_valid"}, 32'(rows_valid), e.rv);
        chk({tag, "_cols_valid"}, 32'(cols_valid), e.cv);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_wgt_load_start"}, 32'(wgt_load_start), 0);
        chk({tag, "_tile_start"}, 32'(tile_start), 0);
        chk_fields(tag, '{0, 0, 0, 0, 0, 0, 0});
    endtask

    // abort_tile >= 1: pull reset while waiting on that tile's tile_done.
    // noise: stray handshakes, stray starts and changing config inputs.
    task automatic run_layer(input int ifm, input int nf, input int abort_tile, input bit noise);
        int   exp_at, wgt_cd, tile_cd, ptr, ntiles, evt_n, kind;
        bit   want_evt, fin;
        evt_t e, cur;
        build_model(ifm, nf);
        @(negedge clk);
        ifm_size   = IW'(ifm);
        num_filter = NW'(nf);
        start      = 1'b1;
        exp_at = 2; wgt_cd = 0; tile_cd = 0; ptr = 0; ntiles = 0; fin = 0;
        cur = '{0, 0, 0, 0, 0, 0, 0};
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0; wgt_load_done = 1'b0; tile_done = 1'b0;
            if (noise) begin
                ifm_size   = IW'($urandom);
                num_filter = NW'($urandom);
            end
            if (exp_at > 0) begin
                exp_at--;
                want_evt = (exp_at == 0);
            end else begin
                want_evt = 0;
            end
            evt_n = int'(done) + int'(tile_start) + int'(wgt_load_start);
            chk("strobe_timing", evt_n, want_evt ? 1 : 0);
            chk("busy_in_layer", 32'(busy), 1);
            if (evt_n >= 1) begin
                kind = done ? 2 : (tile_start ? 1 : 0);
                if (ptr < exp_q.size()) e = exp_q[ptr];
                else e = '{-1, 0, 0, 0, 0, 0, 0};
                ptr++;
                chk("event_kind", kind, e.kind);
                if (kind == 2) begin
                    fin = 1;
                end else if (kind == 1) begin
                    chk_fields("tile", e);
                    cur = e;
                    ntiles++;
                    tile_cd = $urandom_range(1, 3);
                    if (noise) begin
                        tile_done     = 1'($urandom_range(0, 1));
                        wgt_load_done = 1'($urandom_range(0, 1));
                    end
                end else begin
                    chk_fields("wgt", e);
                    wgt_cd = $urandom_range(1, 3);
                    if (noise) begin
                        tile_done     = 1'($urandom_range(0, 1));
                        wgt_load_done = 1'($urandom_range(0, 1));
                    end
                end
            end else if (wgt_cd > 0) begin
                if (noise) begin
                    tile_done = 1'($urandom_range(0, 1));
                    start     = 1'($urandom_range(0, 1));
                end
                wgt_cd--;
                if (wgt_cd == 0) begin
                    wgt_load_done = 1'b1;
                    exp_at = 1;
                end
            end else if (tile_cd > 0) begin
                chk_fields("hold", cur);
                if (ntiles == abort_tile) begin
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("abort");
                    repeat (2) begin
                        @(negedge clk);
                        chk("abort_no_done", 32'(done), 0);
                        chk("abort_idle", 32'(busy), 0);
                    end
                    rst_n = 1'b1;
                    return;
                end
                if (noise) begin
                    wgt_load_done = 1'($urandom_range(0, 1));
                    start         = 1'($urandom_range(0, 1));
                end
                tile_cd--;
                if (tile_cd == 0) begin
                    tile_done = 1'b1;
                    exp_at = 2;
                end
            end
        end
        chk("layer_finished", 32'(fin), 1);
        chk("events_consumed", ptr, exp_q.size());
        start = 1'b0; wgt_load_done = 1'b0; tile_done = 1'b0;
        @(negedge clk);
        chk("idle_after_done_busy", 32'(busy), 0);
        chk("idle_after_done_done", 32'(done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        run_layer(32, 16, -1, 0);
        run_layer(20, 40, -1, 0);
        run_layer(20, 0, -1, 0);
        run_layer(0, 5, -1, 0);
        run_layer(40, 20, -1, 1);
        run_layer(13, 16, -1, 1);
        run_layer(32, 32, 3, 0);
        run_layer(20, 17, -1, 0);
        run_layer(511, 1, -1, 0);
        run_layer(1, 2047, -1, 0);
        for (int i = 0; i < 8; i++) begin
            run_layer($urandom_range(0, 70), $urandom_range(0, 70), -1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
